// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory sequencer.
package lsu_pkg;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } lsu_state_e;

  // Reserved size (2'b11) is aligned like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      LS_BYTE: mis = 1'b0;
      LS_HALF: mis = off[0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane selection with sign or zero extension.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] m_rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data
);

  logic [31:0] byte_lane;
  logic [31:0] half_lane;

  always_comb begin
    byte_lane = m_rdata >> {off, 3'b000};
    half_lane = m_rdata >> {off[1], 4'b0000};
    case (size)
      LS_BYTE: ld_data = {{24{~ld_unsigned & byte_lane[7]}}, byte_lane[7:0]};
      LS_HALF: ld_data = {{16{~ld_unsigned & half_lane[15]}}, half_lane[15:0]};
      default: ld_data = m_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Sequences core loads/stores onto a req/ack data-memory port, stalling the core
// while an access is outstanding and flagging misalignment and bus timeouts.
module lsu_mem_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              ld_en,
  input  logic              st_en,
  input  logic [1:0]        Load_size,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              bus_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_be,
  output logic [31:0]       m_wdata,
  input  logic              m_ack,
  input  logic [31:0]       m_rdata
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  lsu_state_e state_q, state_d;

  logic [7:0]        cnt_q, cnt_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [3:0]        m_be_q, m_be_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;

  logic        op;
  logic        mis;
  logic        start;
  logic [7:0]  cnt_inc;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] ld_data;

  assign op      = ld_en | st_en;
  assign mis     = is_misaligned(Load_size, addr[1:0]);
  assign start   = (state_q == IDLE) & op & ~mis;
  assign cnt_inc = cnt_q + 8'd1;

  // Offset/size/signedness are captured at launch so the aligner does not
  // depend on the core holding its inputs through the access.
  load_align u_load_align (
    .m_rdata     (m_rdata),
    .off         (off_q),
    .size        (size_q),
    .ld_unsigned (uns_q),
    .ld_data     (ld_data)
  );

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_be_q    <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_be_q    <= m_be_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      off_q     <= off_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
    end
  end

  // Ack takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ: begin
        if (m_ack)                       state_d = DONE;
        else if (cnt_inc == TIMEOUT_LIM) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (Load_size)
      LS_BYTE: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      LS_HALF: begin
        be_new    = 4'b0011 << {addr[1], 1'b0};
        wdata_new = {2{wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata;
      end
    endcase
  end

  always_comb begin
    m_addr_d  = m_addr_q;
    m_be_d    = m_be_q;
    m_we_d    = m_we_q;
    m_wdata_d = m_wdata_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    rdata_d   = rdata_q;
    m_req_d   = (state_d == REQ);
    bus_err_d = (state_d == ERR);
    cnt_d     = ((state_q == REQ) && (state_d == REQ)) ? cnt_inc : '0;
    if (start) begin
      m_addr_d  = {addr[ADDR_W-1:2], 2'b00};
      m_be_d    = be_new;
      m_we_d    = st_en;
      m_wdata_d = wdata_new;
      off_d     = addr[1:0];
      size_d    = Load_size;
      uns_d     = ld_unsigned;
    end
    if ((state_q == REQ) && m_ack && !m_we_q) rdata_d = ld_data;
    if (state_d == ERR) rdata_d = '0;
  end

  always_comb begin
    stall    = rst & (start | (state_q == REQ));
    misalign = rst & (state_q == IDLE) & op & mis;
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_be    = m_be_q;
  assign m_wdata = m_wdata_q;
  assign rdata   = rdata_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Randomized self-checking bench for lsu_mem_sequencer against a transaction-level model.
module tb_lsu_mem_sequencer;

  localparam int TO = 6;

  logic        CLK;
  logic        rst;
  logic        ld_en, st_en;
  logic [1:0]  Load_size;
  logic        ld_unsigned;
  logic [31:0] addr, wdata;
  logic        stall, misalign, bus_err;
  logic [31:0] rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_rdata;

  lsu_mem_sequencer #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .CLK(CLK), .rst(rst), .ld_en(ld_en), .st_en(st_en), .Load_size(Load_size),
    .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata), .stall(stall),
    .rdata(rdata), .misalign(misalign), .bus_err(bus_err), .m_req(m_req),
    .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_mis(input int sz, input int off);
    if (sz == 0) return 1'b0;
    if (sz == 1) return (off % 2) != 0;
    return off != 0;
  endfunction

  function automatic logic [31:0] model_be(input int sz, input int off);
    if (sz == 0) return 32'(1 << off);
    if (sz == 1) return 32'(3 << (2 * (off / 2)));
    return 32'hF;
  endfunction

  function automatic logic [31:0] model_wd(input int sz, input logic [31:0] wd);
    if (sz == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_ld(input int sz, input bit uns, input int off, input logic [31:0] w);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // One instruction: lat wait cycles before the ack (ack on REQ cycle lat+1).
  task automatic access(input bit ld, input bit st, input int sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] mr, input int lat);
    bit mis;
    int off;
    int lim;
    int stall_cyc;
    bit timed_out;
    off = int'(a[1:0]);
    mis = model_mis(sz, off);
    timed_out = (lat + 1) > TO;
    lim = timed_out ? TO : lat + 1;
    @(negedge CLK);
    ld_en = ld; st_en = st; Load_size = 2'(sz); ld_unsigned = uns; addr = a; wdata = wd;
    #1;
    chk("misalign", {31'd0, misalign}, {31'd0, mis});
    chk("stall_idle", {31'd0, stall}, {31'd0, !mis});
    if (mis) begin
      @(negedge CLK);
      ld_en = 1'b0; st_en = 1'b0;
      #1;
      chk("mis_noreq", {31'd0, m_req}, 32'd0);
      chk("mis_drop", {31'd0, misalign}, 32'd0);
      return;
    end
    stall_cyc = 1;
    @(negedge CLK);
    for (int c = 1; c <= lim; c++) begin
      chk("req", {31'd0, m_req}, 32'd1);
      chk("we", {31'd0, m_we}, {31'd0, st});
      chk("m_addr", m_addr, a & 32'hFFFF_FFFC);
      chk("m_be", {28'd0, m_be}, model_be(sz, off));
      if (st) chk("m_wdata", m_wdata, model_wd(sz, wd));
      if (stall) stall_cyc++;
      if (c == lat + 1) begin
        m_ack = 1'b1; m_rdata = mr;
      end else begin
        m_rdata = $urandom;
      end
      @(negedge CLK);
      m_ack = 1'b0;
    end
    chk("req_drop", {31'd0, m_req}, 32'd0);
    chk("stall_end", {31'd0, stall}, 32'd0);
    if (timed_out) begin
      exp_rdata = 32'd0;
      chk("bus_err", {31'd0, bus_err}, 32'd1);
      chk("stall_cycles", stall_cyc, TO + 1);
    end else begin
      if (!st) exp_rdata = model_ld(sz, uns, off, mr);
      chk("bus_err_done", {31'd0, bus_err}, 32'd0);
      chk("stall_cycles", stall_cyc, lat + 2);
      m_ack = 1'b1; m_rdata = $urandom;
    end
    chk("rdata", rdata, exp_rdata);
    @(negedge CLK);
    m_ack = 1'b0;
    chk("no_retrigger", {31'd0, m_req}, 32'd0);
    chk("bus_err_pulse", {31'd0, bus_err}, 32'd0);
    chk("rdata_hold", rdata, exp_rdata);
    ld_en = 1'b0; st_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ld_en = 1'b0; st_en = 1'b0; Load_size = 2'b00; ld_unsigned = 1'b0;
    addr = '0; wdata = '0; m_ack = 1'b0; m_rdata = '0; exp_rdata = '0;
    #3;
    chk("rst_req", {31'd0, m_req}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_m_be", {28'd0, m_be}, 32'd0);
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    chk("idle_stall", {31'd0, stall}, 32'd0);

    access(1, 0, 2, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    access(1, 0, 0, 0, 32'h103, 32'h0, 32'h8012_3456, 1);
    access(1, 0, 0, 1, 32'h103, 32'h0, 32'h8012_3456, 0);
    access(0, 1, 1, 0, 32'h22, 32'h0000_ABCD, 32'h0, 5);
    access(1, 0, 2, 0, 32'h101, 32'h0, 32'h0, 0);
    access(0, 1, 2, 0, 32'h2, 32'h1234_5678, 32'h0, 0);
    access(1, 0, 1, 0, 32'h40, 32'h0, 32'h1111_2222, TO + 2);
    access(1, 1, 2, 0, 32'h80, 32'hCAFE_F00D, 32'h5555_AAAA, 0);
    access(1, 0, 1, 0, 32'h46, 32'h0, 32'h9ABC_1234, TO - 1);

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      access(kind != 1, kind == 1 || kind == 2, $urandom_range(0, 3), 1'($urandom),
             $urandom, $urandom, $urandom, $urandom_range(0, TO + 1));
    end

    // Reset in the middle of a request; a late ack must be ignored.
    @(negedge CLK);
    ld_en = 1'b1; Load_size = 2'b10; addr = 32'h200;
    @(negedge CLK);
    chk("pre_rst_req", {31'd0, m_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    exp_rdata = 32'd0;
    chk("rst_mid_req", {31'd0, m_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    @(negedge CLK);
    m_ack = 1'b1; m_rdata = 32'h7777_7777;
    @(negedge CLK);
    m_ack = 1'b0; ld_en = 1'b0;
    rst = 1'b1;
    @(negedge CLK);
    chk("post_rst_req", {31'd0, m_req}, 32'd0);
    chk("post_rst_rdata", rdata, 32'd0);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    access(1, 0, 1, 1, 32'h302, 32'h0, 32'hF00D_8001, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
